// File: rtl/div_ctrl_if.sv
// Pipeline-side request/response bundle for the EX-stage divide sequencer.
// The master is the pipeline; the slave is div_ctrl.
interface div_ctrl_if;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        result_valid;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div0;

    modport master (
        output start, signed_op, op_a, op_b, flush,
        input  busy, result_valid, lo, hi, div0
    );

    modport slave (
        input  start, signed_op, op_a, op_b, flush,
        output busy, result_valid, lo, hi, div0
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer around the iterative unsigned divider: sign handling, div-by-zero, stall and flush/drain.
// Optional macro DIV_CTRL_FASTPATH_EN: |a| < |b| bypasses the divider (lo = 0, hi = op_a).
module div_ctrl #(
    parameter logic [31:0] DIV0_LO      = 32'hFFFF_FFFF,
    parameter bit          DIV0_HI_IS_A = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    div_ctrl_if.slave   pipe,
    output logic        div_en,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state_r;
    logic        div_en_r;
    logic [31:0] div_a_r;
    logic [31:0] div_b_r;
    logic [31:0] raw_a_r;
    logic        qneg_r;
    logic        rneg_r;
    logic        z_r;
    logic        fast_r;
    logic        rv_r;
    logic [31:0] lo_r;
    logic [31:0] hi_r;

    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        z_s;
    logic        fast_s;
    logic        accept_s;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
        neg_if = neg ? (32'd0 - x) : x;
    endfunction

    // Operand magnitudes and early classification of the incoming request.
    always_comb begin
        mag_a_s = neg_if(pipe.signed_op & pipe.op_a[31], pipe.op_a);
        mag_b_s = neg_if(pipe.signed_op & pipe.op_b[31], pipe.op_b);
        z_s     = (pipe.op_b == 32'd0);
`ifdef DIV_CTRL_FASTPATH_EN
        fast_s  = ~z_s & (mag_a_s < mag_b_s);
`else
        fast_s  = 1'b0;
`endif
        accept_s = (state_r == ST_IDLE) & pipe.start & ~pipe.flush;
    end

    // Sequencer state, latched operands and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            div_en_r <= 1'b0;
            div_a_r  <= 32'd0;
            div_b_r  <= 32'd0;
            raw_a_r  <= 32'd0;
            qneg_r   <= 1'b0;
            rneg_r   <= 1'b0;
            z_r      <= 1'b0;
            fast_r   <= 1'b0;
            rv_r     <= 1'b0;
            lo_r     <= 32'd0;
            hi_r     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rv_r <= 1'b0;
                    if (accept_s) begin
                        div_a_r  <= mag_a_s;
                        div_b_r  <= mag_b_s;
                        raw_a_r  <= pipe.op_a;
                        qneg_r   <= pipe.signed_op & (pipe.op_a[31] ^ pipe.op_b[31]);
                        rneg_r   <= pipe.signed_op & pipe.op_a[31];
                        z_r      <= z_s;
                        fast_r   <= fast_s;
                        div_en_r <= ~z_s & ~fast_s;
                        state_r  <= ST_ISSUE;
                    end else begin
                        div_en_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    div_en_r <= 1'b0;
                    // A bypassed request never started the divider, so there is nothing to drain.
                    if (pipe.flush) begin
                        state_r <= (z_r | fast_r) ? ST_IDLE : ST_DRAIN;
                    end else if (z_r) begin
                        lo_r    <= DIV0_LO;
                        hi_r    <= DIV0_HI_IS_A ? raw_a_r : 32'd0;
                        rv_r    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (fast_r) begin
                        lo_r    <= 32'd0;
                        hi_r    <= raw_a_r;
                        rv_r    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    div_en_r <= 1'b0;
                    if (pipe.flush) begin
                        state_r <= ST_DRAIN;
                    end else if (div_done) begin
                        lo_r    <= neg_if(qneg_r, div_q);
                        hi_r    <= neg_if(rneg_r, div_r);
                        rv_r    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    div_en_r <= 1'b0;
                    rv_r     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                ST_DRAIN: begin
                    div_en_r <= 1'b0;
                    rv_r     <= 1'b0;
                    if (div_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    div_en_r <= 1'b0;
                    rv_r     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances alongside result_valid.
    assign pipe.busy         = ((state_r != ST_IDLE) & (state_r != ST_DONE)) | accept_s;
    assign pipe.result_valid = rv_r & ~pipe.flush;
    assign pipe.div0         = rv_r & z_r & ~pipe.flush;
    assign pipe.lo           = lo_r;
    assign pipe.hi           = hi_r;
    assign div_en            = div_en_r;
    assign div_a             = div_a_r;
    assign div_b             = div_b_r;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 17-cycle divider that only restarts on new operands.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        div_en;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    int n_cmp;
    int n_err;

    div_ctrl_if ifc ();

    div_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .pipe     (ifc.slave),
        .div_en   (div_en),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_done (div_done),
        .div_q    (div_q),
        .div_r    (div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: busy for cycles 2..18 after an enable with a new operand pair.
    logic [31:0] last_a;
    logic [31:0] last_b;
    int          dcnt;
    always @(posedge clk) begin
        if (rst) begin
            last_a <= 32'd0;
            last_b <= 32'd0;
            div_q  <= 32'd0;
            div_r  <= 32'd0;
            dcnt   <= 0;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end else if (div_en && ((div_a != last_a) || (div_b != last_b))) begin
            last_a <= div_a;
            last_b <= div_b;
            div_q  <= (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
            div_r  <= (div_b == 32'd0) ? div_a : div_a % div_b;
            dcnt   <= 17;
        end
    end
    assign div_done = (dcnt == 0);

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] elo, input logic [31:0] ehi,
                          input logic ediv0, input int een);
        int cyc;
        int en_seen;
        int busy_low;
        bit got;
        cyc = 0; en_seen = 0; busy_low = 0; got = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.signed_op = s; ifc.op_a = a; ifc.op_b = b;
        #1;
        chk_int({tag, ":busy_c0"}, int'(ifc.busy), 1);
        @(posedge clk);
        #1;
        ifc.start = 1'b0; ifc.signed_op = ~s; ifc.op_a = 32'hDEAD_BEEF; ifc.op_b = 32'h0000_1234;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (div_en) en_seen++;
            if (ifc.result_valid) got = 1'b1;
            else if (!ifc.busy) busy_low++;
        end
        chk_int({tag, ":got"}, int'(got), 1);
        chk_int({tag, ":latency"}, cyc, lat);
        chk_int({tag, ":busy_done"}, int'(ifc.busy), 0);
        chk32({tag, ":lo"}, ifc.lo, elo);
        chk32({tag, ":hi"}, ifc.hi, ehi);
        chk_int({tag, ":div0"}, int'(ifc.div0), int'(ediv0));
        chk_int({tag, ":div_en_pulses"}, en_seen, een);
        chk_int({tag, ":busy_gaps"}, busy_low, 0);
        @(negedge clk);
        chk_int({tag, ":rv_pulse"}, int'(ifc.result_valid), 0);
        chk32({tag, ":lo_hold"}, ifc.lo, elo);
    endtask

    initial begin
        int cyc;
        int rv_seen;
        int first_idle;
        int en_seen;
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        ifc.start = 1'b0; ifc.signed_op = 1'b0; ifc.op_a = 32'd0; ifc.op_b = 32'd0; ifc.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk_int("rst:busy", int'(ifc.busy), 0);
        chk_int("rst:rv", int'(ifc.result_valid), 0);
        chk_int("rst:div0", int'(ifc.div0), 0);
        chk32("rst:lo", ifc.lo, 32'd0);
        chk32("rst:hi", ifc.hi, 32'd0);
        chk_int("rst:div_en", int'(div_en), 0);
        chk32("rst:div_a", div_a, 32'd0);
        chk32("rst:div_b", div_b, 32'd0);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 20, 32'd14, 32'd2, 1'b0, 1);
        run_op("divu_repeat", 1'b0, 32'd100, 32'd7, 3, 32'd14, 32'd2, 1'b0, 1);
        run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 3, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 3, 32'hFFFF_FFF2, 32'd2, 1'b0, 1);
        run_op("div_by_zero", 1'b1, 32'h8000_0000, 32'd0, 2, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
        run_op("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 20, 32'h8000_0000, 32'd0, 1'b0, 1);

        // Flush in IDLE beats start: nothing is accepted.
        @(negedge clk);
        ifc.start = 1'b1; ifc.flush = 1'b1; ifc.signed_op = 1'b0; ifc.op_a = 32'd5; ifc.op_b = 32'd1;
        #1;
        chk_int("idle_flush:busy_c0", int'(ifc.busy), 0);
        @(posedge clk);
        #1 ifc.start = 1'b0; ifc.flush = 1'b0;
        @(negedge clk);
        chk_int("idle_flush:busy_c1", int'(ifc.busy), 0);
        chk_int("idle_flush:div_en", int'(div_en), 0);
        chk32("idle_flush:lo", ifc.lo, 32'h8000_0000);

        // Flush in WAIT at cycle 5, with a stray start during the drain.
        @(negedge clk);
        ifc.start = 1'b1; ifc.signed_op = 1'b0; ifc.op_a = 32'd1000; ifc.op_b = 32'd3;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        cyc = 0; rv_seen = 0; first_idle = 0; en_seen = 0;
        while (cyc < 24) begin
            @(negedge clk);
            cyc++;
            if (ifc.result_valid) rv_seen++;
            if (div_en) en_seen++;
            if (!ifc.busy && first_idle == 0) first_idle = cyc;
            ifc.flush = (cyc == 5);
            ifc.start = (cyc == 8);
            if (cyc == 8) begin
                ifc.signed_op = 1'b1; ifc.op_a = 32'd77; ifc.op_b = 32'd5;
            end
        end
        chk_int("flush:rv_count", rv_seen, 0);
        chk_int("flush:first_idle", first_idle, 20);
        chk_int("flush:div_en_pulses", en_seen, 1);
        chk32("flush:lo_kept", ifc.lo, 32'h8000_0000);
        chk32("flush:hi_kept", ifc.hi, 32'd0);

        run_op("divu_9_2", 1'b0, 32'd9, 32'd2, 20, 32'd4, 32'd1, 1'b0, 1);

`ifdef DIV_CTRL_FASTPATH_EN
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 2, 32'd0, 32'd3, 1'b0, 0);
`else
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 20, 32'd0, 32'd3, 1'b0, 1);
`endif

        // Synchronous reset while waiting on the divider.
        @(negedge clk);
        ifc.start = 1'b1; ifc.signed_op = 1'b0; ifc.op_a = 32'd50; ifc.op_b = 32'd6;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_int("rst_wait:busy_before", int'(ifc.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_int("rst_wait:busy", int'(ifc.busy), 0);
        chk_int("rst_wait:rv", int'(ifc.result_valid), 0);
        chk32("rst_wait:lo", ifc.lo, 32'd0);
        chk32("rst_wait:hi", ifc.hi, 32'd0);

        run_op("post_rst", 1'b0, 32'd100, 32'd7, 20, 32'd14, 32'd2, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
